pwm_bank: RTL

Parametrised multi-channel PWM generator that generalises the fixed fan-PWM and LED-blink dividers in the top level into NCH independent channels. Each channel has a programmable period, duty, enable and polarity. New settings are double-buffered so they take effect only at a period boundary, and all channels share one clock prescaler. Period, duty and control inputs are driven from AXI-lite register-file words; outputs go to pins such as `fan_pwm` and `pl_led1`.

---
 rtl/pwm_bank.sv | 106 ++++++++++
 1 files changed

// File: rtl/pwm_bank.sv
// pwm_bank: NCH-channel PWM generator with a shared prescaler.
// Period/duty are double-buffered and load at each channel's wrap.
module pwm_bank #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int PSW = 8
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic [PSW-1:0]    prescale,
  input  logic [NCH-1:0]    enable,
  input  logic [NCH-1:0]    invert,
  input  logic [NCH*CW-1:0] period,
  input  logic [NCH*CW-1:0] duty,
  input  logic              update,
  output logic [NCH-1:0]    pwm_out,
  output logic [NCH-1:0]    wrap,
  output logic              update_pending
);

  logic [PSW-1:0] pcnt;
  logic           tick;
  logic [NCH-1:0] pend;

  // >= so that lowering prescale below pcnt ticks at once
  assign tick = (pcnt >= prescale);

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PSW'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] act_per;
    logic [CW-1:0] act_duty;
    logic [CW-1:0] pnd_per;
    logic [CW-1:0] pnd_duty;
    logic [CW-1:0] in_per;
    logic [CW-1:0] in_duty;
    logic          pend_q;
    logic          pwm_q;
    logic          wrap_q;
    logic          at_end;

    assign in_per  = period[i*CW +: CW];
    assign in_duty = duty[i*CW +: CW];
    assign at_end  = tick && (cnt == act_per);

    always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
        cnt      <= '0;
        act_per  <= '0;
        act_duty <= '0;
        pnd_per  <= '0;
        pnd_duty <= '0;
        pend_q   <= 1'b0;
        pwm_q    <= 1'b0;
        wrap_q   <= 1'b0;
      end else if (!enable[i]) begin
        cnt      <= '0;
        pend_q   <= 1'b0;
        act_per  <= in_per;
        act_duty <= in_duty;
        wrap_q   <= 1'b0;
        pwm_q    <= invert[i];
      end else begin
        wrap_q <= at_end;
        pwm_q  <= (cnt < act_duty) ^ invert[i];
        if (at_end) begin
          cnt    <= '0;
          pend_q <= 1'b0;
          // a coincident update bypasses the shadow
          if (update) begin
            act_per  <= in_per;
            act_duty <= in_duty;
          end else if (pend_q) begin
            act_per  <= pnd_per;
            act_duty <= pnd_duty;
          end
        end else begin
          if (tick) begin
            cnt <= cnt + CW'(1);
          end
          if (update) begin
            pnd_per  <= in_per;
            pnd_duty <= in_duty;
            pend_q   <= 1'b1;
          end
        end
      end
    end

    assign pwm_out[i] = pwm_q;
    assign wrap[i]    = wrap_q;
    assign pend[i]    = pend_q;
  end

  assign update_pending = |pend;

endmodule
